// File: rtl/shift_right_iter_32bit_pkg.sv
// -----------------------------------------------------------------------------
// shift_right_iter_32bit_pkg
// Shared definitions for the iterative right shifter and the datapath control
// unit: default operand/shift-amount widths, FSM state encoding and the
// sign-fill helper used by the single-step stage.
// -----------------------------------------------------------------------------
package shift_right_iter_32bit_pkg;

  localparam int SHR_WIDTH   = 32;
  localparam int SHR_SHAMT_W = 5;

  // State encoding is fixed so the control unit can decode it directly.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shr_state_e;

  // Bit shifted into the MSB on each step: the current sign bit for an
  // arithmetic shift, zero for a logical one.
  function automatic logic shr_fill_bit(input logic arith_mode, input logic msb);
    return arith_mode & msb;
  endfunction

endpackage : shift_right_iter_32bit_pkg

// File: rtl/shift_right_iter_32bit_if.sv
// -----------------------------------------------------------------------------
// shift_right_iter_32bit_if
// Request/response bundle between the control unit (master) and the iterative
// right shifter (slave).
//   start   : request, accepted only while busy=0
//   arith   : 1 = arithmetic (sign fill), 0 = logical (zero fill)
//   shamt   : shift amount 0..WIDTH-1
//   operand : value to shift
//   busy    : operation in flight (SHIFT or DONE)
//   done    : one-cycle completion pulse
//   result  : shifted value, valid on done and held afterwards
// -----------------------------------------------------------------------------
interface shift_right_iter_32bit_if
  import shift_right_iter_32bit_pkg::*;
#(
  parameter int WIDTH   = SHR_WIDTH,
  parameter int SHAMT_W = SHR_SHAMT_W
);

  logic               start;
  logic               arith;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   operand;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, arith, shamt, operand,
    input  busy, done, result
  );

  modport slave (
    input  start, arith, shamt, operand,
    output busy, done, result
  );

endinterface : shift_right_iter_32bit_if

// File: rtl/shift_right_iter_32bit_stage.sv
// -----------------------------------------------------------------------------
// shift_right_1bit_32bit
// Combinational single-step right shift stage.
//   data_in   : value before the step
//   fill_sign : bit inserted at the MSB
//   data_out  : data_in shifted right by one
// -----------------------------------------------------------------------------
module shift_right_1bit_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             fill_sign,
  output logic [WIDTH-1:0] data_out
);

  assign data_out = {fill_sign, data_in[WIDTH-1:1]};

endmodule : shift_right_1bit_32bit

// File: rtl/shift_right_iter_32bit.sv
// -----------------------------------------------------------------------------
// shift_right_iter_32bit
// Multi-cycle SRL/SRA unit: shifts one bit per clock after a start/done
// handshake. The control unit stalls the pipeline while busy=1.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; clears all state
//   bus   : slave side of shift_right_iter_32bit_if (start/arith/shamt/operand
//           in, busy/done/result out); all outputs come straight from flops
// -----------------------------------------------------------------------------
module shift_right_iter_32bit
  import shift_right_iter_32bit_pkg::*;
#(
  parameter int WIDTH   = SHR_WIDTH,
  parameter int SHAMT_W = SHR_SHAMT_W
) (
  input logic                     clk,
  input logic                     reset,
  shift_right_iter_32bit_if.slave bus
);

  localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   DATA_ZERO = {WIDTH{1'b0}};

  shr_state_e         state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fill_s;
  logic [WIDTH-1:0]   step_s;

  // Sign fill reads the live MSB; it never changes under SRA, so it stays the
  // original operand sign for the whole operation.
  assign fill_s = shr_fill_bit(mode_q, shreg_q[WIDTH-1]);

  shift_right_1bit_32bit #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_in   (shreg_q),
    .fill_sign (fill_s),
    .data_out  (step_s)
  );

  // Next-state, datapath and output decode for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.operand;
          cnt_d   = bus.shamt;
          mode_d  = bus.arith;
          if (bus.shamt != CNT_ZERO) begin
            state_d = ST_SHIFT;
          end else begin
            // Zero shift completes without a SHIFT cycle.
            state_d  = ST_DONE;
            result_d = bus.operand;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        shreg_d = step_s;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Capture the final step now so result is already valid while done=1.
          state_d  = ST_DONE;
          result_d = step_s;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= DATA_ZERO;
      cnt_q    <= CNT_ZERO;
      mode_q   <= 1'b0;
      result_q <= DATA_ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule : shift_right_iter_32bit

// File: tb/tb_shift_right_iter_32bit.sv
// -----------------------------------------------------------------------------
// tb_shift_right_iter_32bit
// Directed bench for the iterative right shifter: hand-computed results,
// done latency, busy window, ignored mid-operation start and mid-operation
// reset.
// -----------------------------------------------------------------------------
module tb_shift_right_iter_32bit;

  logic clk;
  logic reset;

  int checks_cnt;
  int errors_cnt;

  shift_right_iter_32bit_if bus_if ();

  shift_right_iter_32bit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then follow it cycle by cycle until done.
  // If inject is set, a conflicting start is pulsed during SHIFT.
  task automatic run_op(input string tag, input logic arith, input logic [4:0] shamt,
                        input logic [31:0] operand, input logic [31:0] exp_res,
                        input bit inject);
    int got;
    got = 0;
    @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.arith   = arith;
    bus_if.shamt   = shamt;
    bus_if.operand = operand;
    @(posedge clk);
    #1;
    bus_if.start   = 1'b0;
    bus_if.operand = 32'h0BAD_F00D;
    bus_if.shamt   = 5'd3;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (inject && k == 2) begin
        bus_if.start   = 1'b1;
        bus_if.arith   = ~arith;
        bus_if.shamt   = 5'd1;
        bus_if.operand = 32'h1234_5678;
      end else begin
        bus_if.start = 1'b0;
      end
      check_eq({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd1);
      if (bus_if.done) begin
        got = k;
        break;
      end
    end
    bus_if.start = 1'b0;
    check_eq({tag, "_lat"}, 32'(got), 32'(int'(shamt) + 1));
    check_eq({tag, "_res"}, bus_if.result, exp_res);
    @(negedge clk);
    check_eq({tag, "_done_clr"}, {31'd0, bus_if.done}, 32'd0);
    check_eq({tag, "_busy_clr"}, {31'd0, bus_if.busy}, 32'd0);
    check_eq({tag, "_hold"}, bus_if.result, exp_res);
  endtask

  initial begin
    int done_seen;
    checks_cnt     = 0;
    errors_cnt     = 0;
    reset          = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.arith   = 1'b0;
    bus_if.shamt   = 5'd0;
    bus_if.operand = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus_if.done}, 32'd0);
    check_eq("rst_res",  bus_if.result, 32'd0);
    reset = 1'b0;

    run_op("srl4",     1'b0, 5'd4,  32'h8000_0000, 32'h0800_0000, 1'b0);
    run_op("sra4_neg", 1'b1, 5'd4,  32'h8000_0000, 32'hF800_0000, 1'b0);
    run_op("sra4_pos", 1'b1, 5'd4,  32'h7000_0000, 32'h0700_0000, 1'b0);
    run_op("sh0",      1'b1, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    run_op("srl31",    1'b0, 5'd31, 32'h8000_0001, 32'h0000_0001, 1'b0);
    run_op("sra31",    1'b1, 5'd31, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("ignore",   1'b0, 5'd4,  32'h8000_0000, 32'h0800_0000, 1'b1);

    // Reset during cycle T+2 of a shamt=10 operation.
    @(negedge clk);
    bus_if.start   = 1'b1;
    bus_if.arith   = 1'b1;
    bus_if.shamt   = 5'd10;
    bus_if.operand = 32'h8000_0000;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_busy", {31'd0, bus_if.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mrst_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("mrst_done", {31'd0, bus_if.done}, 32'd0);
    check_eq("mrst_res",  bus_if.result, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus_if.done || bus_if.busy) begin
        done_seen++;
      end
    end
    check_eq("mrst_no_done", 32'(done_seen), 32'd0);

    run_op("post_rst", 1'b0, 5'd8, 32'h0000_F000, 32'h0000_00F0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_shift_right_iter_32bit
